clks_alot_lock_ctrl: RTL and testbench

Lock/pause controller for the clock-recovery datapath. It consumes per-period half-rate measurements and edge events from the recovery front end, and compares them against configured lock-in rates and skew. It sequences the recovery unit through acquire, locked, paused and hold-off states, and drives the status_s fields (locked, pause_active, pause_duration) that are published in clock_state_s.

---
 rtl/clks_alot_lock_ctrl_pkg.sv | 24 ++
 rtl/clks_alot_lock_ctrl_if.sv | 54 +++++
 rtl/clks_alot_band_check.sv | 19 +
 rtl/clks_alot_lock_ctrl.sv | 208 ++++++++++++++++++++
 tb/tb_clks_alot_lock_ctrl.sv | 193 +++++++++++++++++++
 5 files changed

// File: rtl/clks_alot_lock_ctrl_pkg.sv
// Shared types and defaults for the clock-recovery lock/pause controller.
package clks_alot_p;

    localparam int RATE_COUNTER_WIDTH    = 32;
    localparam int DRIFT_COUNTER_WIDTH   = 16;
    localparam int LOCK_MATCHES_DEFAULT  = 8;
    localparam int UNLOCK_MISSES_DEFAULT = 4;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ACQUIRE = 3'd1,
        LOCKED  = 3'd2,
        PAUSED  = 3'd3,
        HOLDOFF = 3'd4
    } lock_state_e;

    typedef struct packed {
        logic [RATE_COUNTER_WIDTH-1:0] high_lockin;
        logic [RATE_COUNTER_WIDTH-1:0] high_skew;
        logic [RATE_COUNTER_WIDTH-1:0] low_lockin;
        logic [RATE_COUNTER_WIDTH-1:0] low_skew;
    } lock_limits_s;

endpackage

// File: rtl/clks_alot_lock_ctrl_if.sv
// Measurement, configuration and status bundle between the recovery front end and the lock controller.
// With CLKS_ALOT_LOCK_STATS_EN defined the bundle also carries the lock-loss and pause-entry counters.
interface clks_alot_lock_ctrl_if #(
    parameter int COUNTER_WIDTH = 32
);
    import clks_alot_p::*;

    logic                     enable_i;
    logic                     pausable_i;
    logic                     even_50_50_i;
    logic                     rate_valid_i;
    logic [COUNTER_WIDTH-1:0] high_rate_i;
    logic [COUNTER_WIDTH-1:0] low_rate_i;
    logic                     edge_i;
    logic                     violation_i;
    logic [COUNTER_WIDTH-1:0] high_lockin_i;
    logic [COUNTER_WIDTH-1:0] low_lockin_i;
    logic [COUNTER_WIDTH-1:0] high_skew_i;
    logic [COUNTER_WIDTH-1:0] low_skew_i;
    logic [COUNTER_WIDTH-1:0] pause_threshold_i;
    logic                     locked_o;
    logic                     pause_active_o;
    logic [COUNTER_WIDTH-1:0] pause_duration_o;
    logic                     lock_acquired_o;
    logic                     lock_lost_o;
    logic                     pause_violation_o;
`ifdef CLKS_ALOT_LOCK_STATS_EN
    logic [DRIFT_COUNTER_WIDTH-1:0] lock_loss_count_o;
    logic [DRIFT_COUNTER_WIDTH-1:0] pause_count_o;
`endif

    modport master (
        output enable_i, pausable_i, even_50_50_i, rate_valid_i, high_rate_i, low_rate_i,
               edge_i, violation_i, high_lockin_i, low_lockin_i, high_skew_i, low_skew_i,
               pause_threshold_i,
`ifdef CLKS_ALOT_LOCK_STATS_EN
        input  lock_loss_count_o, pause_count_o,
`endif
        input  locked_o, pause_active_o, pause_duration_o, lock_acquired_o, lock_lost_o,
               pause_violation_o
    );

    modport slave (
        input  enable_i, pausable_i, even_50_50_i, rate_valid_i, high_rate_i, low_rate_i,
               edge_i, violation_i, high_lockin_i, low_lockin_i, high_skew_i, low_skew_i,
               pause_threshold_i,
`ifdef CLKS_ALOT_LOCK_STATS_EN
        output lock_loss_count_o, pause_count_o,
`endif
        output locked_o, pause_active_o, pause_duration_o, lock_acquired_o, lock_lost_o,
               pause_violation_o
    );

endinterface

// File: rtl/clks_alot_band_check.sv
// Combinational check that a measured half-period lies within +/- skew of its lock-in target.
module clks_alot_band_check #(
    parameter int COUNTER_WIDTH = 32
) (
    input  logic [COUNTER_WIDTH-1:0] rate,
    input  logic [COUNTER_WIDTH-1:0] lockin,
    input  logic [COUNTER_WIDTH-1:0] skew,
    output logic                     in_band
);
    logic [COUNTER_WIDTH:0] diff;

    always_comb begin
        if (rate >= lockin) diff = {1'b0, rate} - {1'b0, lockin};
        else                diff = {1'b0, lockin} - {1'b0, rate};
    end

    assign in_band = (diff <= {1'b0, skew});

endmodule

// File: rtl/clks_alot_lock_ctrl.sv
// Lock/pause controller: sequences clock recovery through ACQUIRE, LOCKED, PAUSED and HOLDOFF.
// Optional CLKS_ALOT_LOCK_STATS_EN adds saturating lock-loss and pause-entry counters.
module clks_alot_lock_ctrl
    import clks_alot_p::*;
#(
    parameter int COUNTER_WIDTH = 32,
    parameter int LOCK_MATCHES  = LOCK_MATCHES_DEFAULT,
    parameter int UNLOCK_MISSES = UNLOCK_MISSES_DEFAULT
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    clks_alot_lock_ctrl_if.slave bus
);
    localparam int PW = COUNTER_WIDTH + 2;

    function automatic logic [COUNTER_WIDTH-1:0] sat_inc(input logic [COUNTER_WIDTH-1:0] v);
        return (&v) ? v : v + COUNTER_WIDTH'(1);
    endfunction

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (&v) ? v : v + 8'd1;
    endfunction

    lock_state_e              state_q, state_d;
    logic [7:0]               match_q, match_d, miss_q, miss_d;
    logic [COUNTER_WIDTH-1:0] idle_q, idle_d, duration_q, duration_d;
    logic [PW-1:0]            period_q, period_d, period_last;
    logic                     locked_q, locked_d, pause_active_q, pause_active_d;
    logic                     acq_q, acq_d, lost_q, lost_d, pviol_q, pviol_d, pause_entry;
    logic                     high_ok, low_ok, good, bad;

    clks_alot_band_check #(.COUNTER_WIDTH(COUNTER_WIDTH)) u_high (
        .rate(bus.high_rate_i), .lockin(bus.high_lockin_i), .skew(bus.high_skew_i), .in_band(high_ok)
    );

    // In 50/50 mode the low half is held to the high-half target and skew.
    clks_alot_band_check #(.COUNTER_WIDTH(COUNTER_WIDTH)) u_low (
        .rate   (bus.low_rate_i),
        .lockin (bus.even_50_50_i ? bus.high_lockin_i : bus.low_lockin_i),
        .skew   (bus.even_50_50_i ? bus.high_skew_i   : bus.low_skew_i),
        .in_band(low_ok)
    );

    assign bad         = bus.violation_i | (bus.rate_valid_i & ~(high_ok & low_ok));
    assign good        = bus.rate_valid_i & high_ok & low_ok & ~bus.violation_i;
    assign period_last = {2'b00, bus.high_lockin_i} + {2'b00, bus.low_lockin_i} + PW'(1);

    always_comb begin
        state_d        = state_q;
        match_d        = match_q;
        miss_d         = miss_q;
        idle_d         = idle_q;
        period_d       = period_q;
        duration_d     = duration_q;
        locked_d       = locked_q;
        pause_active_d = pause_active_q;
        acq_d          = 1'b0;
        lost_d         = 1'b0;
        pviol_d        = 1'b0;
        pause_entry    = 1'b0;

        if (!bus.enable_i) begin
            state_d        = IDLE;
            match_d        = '0;
            miss_d         = '0;
            idle_d         = '0;
            period_d       = '0;
            duration_d     = '0;
            locked_d       = 1'b0;
            pause_active_d = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    state_d = ACQUIRE;
                    match_d = '0;
                end
                ACQUIRE: begin
                    if (bad) begin
                        match_d = '0;
                    end else if (good) begin
                        match_d = sat_inc8(match_q);
                        if ({1'b0, match_q} + 9'd1 >= 9'(LOCK_MATCHES)) begin
                            state_d  = LOCKED;
                            locked_d = 1'b1;
                            acq_d    = 1'b1;
                            miss_d   = '0;
                            idle_d   = '0;
                        end
                    end
                end
                LOCKED: begin
                    idle_d = bus.edge_i ? '0 : sat_inc(idle_q);
                    if (bad)       miss_d = sat_inc8(miss_q);
                    else if (good) miss_d = '0;
                    if (bad && miss_d >= 8'(UNLOCK_MISSES)) begin
                        state_d  = ACQUIRE;
                        locked_d = 1'b0;
                        lost_d   = 1'b1;
                        match_d  = '0;
                        miss_d   = '0;
                        idle_d   = '0;
                    end else if (!bus.edge_i && idle_q == bus.pause_threshold_i) begin
                        if (bus.pausable_i) begin
                            state_d        = PAUSED;
                            pause_active_d = 1'b1;
                            duration_d     = '0;
                            period_d       = '0;
                            pause_entry    = 1'b1;
                        end else begin
                            state_d  = ACQUIRE;
                            locked_d = 1'b0;
                            lost_d   = 1'b1;
                            pviol_d  = 1'b1;
                            match_d  = '0;
                            miss_d   = '0;
                            idle_d   = '0;
                        end
                    end
                end
                PAUSED: begin
                    idle_d = bus.edge_i ? '0 : sat_inc(idle_q);
                    if (bus.edge_i) begin
                        state_d        = HOLDOFF;
                        pause_active_d = 1'b0;
                        idle_d         = '0;
                    end else if (period_q == period_last) begin
                        period_d   = '0;
                        duration_d = sat_inc(duration_q);
                    end else begin
                        period_d = period_q + PW'(1);
                    end
                end
                HOLDOFF: begin
                    // The first period after a pause is partial, so its measurement is dropped.
                    if (bus.violation_i) begin
                        state_d  = ACQUIRE;
                        locked_d = 1'b0;
                        lost_d   = 1'b1;
                        match_d  = '0;
                        miss_d   = '0;
                    end else if (bus.rate_valid_i) begin
                        state_d = LOCKED;
                        miss_d  = '0;
                        idle_d  = '0;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q        <= IDLE;
            match_q        <= '0;
            miss_q         <= '0;
            idle_q         <= '0;
            period_q       <= '0;
            duration_q     <= '0;
            locked_q       <= 1'b0;
            pause_active_q <= 1'b0;
            acq_q          <= 1'b0;
            lost_q         <= 1'b0;
            pviol_q        <= 1'b0;
        end else begin
            state_q        <= state_d;
            match_q        <= match_d;
            miss_q         <= miss_d;
            idle_q         <= idle_d;
            period_q       <= period_d;
            duration_q     <= duration_d;
            locked_q       <= locked_d;
            pause_active_q <= pause_active_d;
            acq_q          <= acq_d;
            lost_q         <= lost_d;
            pviol_q        <= pviol_d;
        end
    end

    assign bus.locked_o          = locked_q;
    assign bus.pause_active_o    = pause_active_q;
    assign bus.pause_duration_o  = duration_q;
    assign bus.lock_acquired_o   = acq_q;
    assign bus.lock_lost_o       = lost_q;
    assign bus.pause_violation_o = pviol_q;

`ifdef CLKS_ALOT_LOCK_STATS_EN
    logic [DRIFT_COUNTER_WIDTH-1:0] loss_cnt_q, pause_cnt_q;

    // Statistics survive enable_i toggling; only reset clears them.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            loss_cnt_q  <= '0;
            pause_cnt_q <= '0;
        end else begin
            if (lost_d && !(&loss_cnt_q))       loss_cnt_q  <= loss_cnt_q + DRIFT_COUNTER_WIDTH'(1);
            if (pause_entry && !(&pause_cnt_q)) pause_cnt_q <= pause_cnt_q + DRIFT_COUNTER_WIDTH'(1);
        end
    end

    assign bus.lock_loss_count_o = loss_cnt_q;
    assign bus.pause_count_o     = pause_cnt_q;
`else
    logic unused_pause_entry;
    assign unused_pause_entry = pause_entry;
`endif

endmodule

// File: tb/tb_clks_alot_lock_ctrl.sv
// Directed scoreboard bench for clks_alot_lock_ctrl: lock, loss, pause, holdoff, 50/50 and reset.
module tb_clks_alot_lock_ctrl;

    typedef struct packed {
        logic        locked;
        logic        pause_active;
        logic        acq;
        logic        lost;
        logic        pviol;
        logic [31:0] dur;
    } st_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks   = 0;
    int   failures = 0;
    st_t  exp_q[$];
    string tag_q[$];

    always #5 clk = ~clk;

    clks_alot_lock_ctrl_if #(.COUNTER_WIDTH(32)) bus ();

    clks_alot_lock_ctrl #(
        .COUNTER_WIDTH(32),
        .LOCK_MATCHES (8),
        .UNLOCK_MISSES(4)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (bus)
    );

    function automatic st_t mk(input logic lk, input logic pa, input logic acq,
                               input logic lost, input logic pv, input int dur);
        st_t s;
        s.locked = lk; s.pause_active = pa; s.acq = acq; s.lost = lost; s.pviol = pv;
        s.dur = 32'(dur);
        return s;
    endfunction

    task automatic push_exp(input string tag, input st_t e);
        exp_q.push_back(e);
        tag_q.push_back(tag);
    endtask

    task automatic pop_check();
        st_t   e, o;
        string t;
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        o = {bus.locked_o, bus.pause_active_o, bus.lock_acquired_o, bus.lock_lost_o,
             bus.pause_violation_o, bus.pause_duration_o};
        checks++;
        assert (o === e) else begin
            failures++;
            $error("FAIL %s observed=%h required=%h (lk,pa,acq,lost,pviol,dur)", t, o, e);
        end
    endtask

    task automatic drive(input logic rv, input int hr, input int lr, input logic e, input logic v);
        bus.rate_valid_i = rv;
        bus.high_rate_i  = 32'(hr);
        bus.low_rate_i   = 32'(lr);
        bus.edge_i       = e;
        bus.violation_i  = v;
        @(posedge clk);
        #1;
        bus.rate_valid_i = 1'b0;
        bus.edge_i       = 1'b0;
        bus.violation_i  = 1'b0;
    endtask

    task automatic step(input string tag, input logic rv, input int hr, input int lr,
                        input logic e, input logic v, input st_t ex);
        push_exp(tag, ex);
        drive(rv, hr, lr, e, v);
        pop_check();
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 0, 0, 1'b0, 1'b0);
    endtask

    task automatic pulses(input int n, input int hr, input int lr);
        for (int i = 0; i < n; i++) drive(1'b1, hr, lr, 1'b1, 1'b0);
    endtask

    initial begin
        bus.enable_i = 1'b0; bus.pausable_i = 1'b1; bus.even_50_50_i = 1'b0;
        bus.rate_valid_i = 1'b0; bus.high_rate_i = '0; bus.low_rate_i = '0;
        bus.edge_i = 1'b0; bus.violation_i = 1'b0;
        bus.high_lockin_i = 32'd10; bus.low_lockin_i = 32'd10;
        bus.high_skew_i = 32'd1; bus.low_skew_i = 32'd1; bus.pause_threshold_i = 32'd50;

        repeat (3) @(posedge clk);
        #1;
        push_exp("reset_state", mk(0, 0, 0, 0, 0, 0));
        pop_check();
        rst = 1'b0;
        bus.enable_i = 1'b1;
        idle_cycles(1);

        // Acquire with 10/11 rates (within skew 1)
        pulses(6, 10, 11);
        step("pre_lock_7th", 1'b1, 10, 11, 1'b1, 1'b0, mk(0, 0, 0, 0, 0, 0));
        step("lock_8th",     1'b1, 10, 11, 1'b1, 1'b0, mk(1, 0, 1, 0, 0, 0));
        step("acq_one_cycle", 1'b0, 0, 0, 1'b0, 1'b0, mk(1, 0, 0, 0, 0, 0));

        // Miss counting: 3 bad, 1 good, then 4 bad
        pulses(2, 10, 14);
        step("miss3_hold", 1'b1, 10, 14, 1'b1, 1'b0, mk(1, 0, 0, 0, 0, 0));
        pulses(1, 10, 10);
        pulses(3, 10, 14);
        step("miss4_loss",   1'b1, 10, 14, 1'b1, 1'b0, mk(0, 0, 0, 1, 0, 0));
        step("lost_one_cycle", 1'b0, 0, 0, 1'b0, 1'b0, mk(0, 0, 0, 0, 0, 0));

        // Pause with pausable=1, period 22
        pulses(7, 10, 10);
        step("relock",      1'b1, 10, 10, 1'b1, 1'b0, mk(1, 0, 1, 0, 0, 0));
        step("last_edge",   1'b0, 0, 0, 1'b1, 1'b0, mk(1, 0, 0, 0, 0, 0));
        idle_cycles(49);
        step("pre_pause",   1'b0, 0, 0, 1'b0, 1'b0, mk(1, 0, 0, 0, 0, 0));
        step("pause_entry", 1'b0, 0, 0, 1'b0, 1'b0, mk(1, 1, 0, 0, 0, 0));
        idle_cycles(42);
        step("pause_dur1",  1'b0, 0, 0, 1'b0, 1'b0, mk(1, 1, 0, 0, 0, 1));
        step("pause_dur2",  1'b0, 0, 0, 1'b0, 1'b0, mk(1, 1, 0, 0, 0, 2));
        idle_cycles(5);
        step("pause_exit",  1'b0, 0, 0, 1'b1, 1'b0, mk(1, 0, 0, 0, 0, 2));
        step("holdoff_discard", 1'b1, 10, 14, 1'b1, 1'b0, mk(1, 0, 0, 0, 0, 2));
        pulses(2, 10, 14);
        step("holdoff_miss_clear", 1'b1, 10, 14, 1'b1, 1'b0, mk(1, 0, 0, 0, 0, 2));
        pulses(1, 10, 10);

        // Pause with pausable=0 is a violation
        bus.pausable_i = 1'b0;
        step("edge_np",     1'b0, 0, 0, 1'b1, 1'b0, mk(1, 0, 0, 0, 0, 2));
        idle_cycles(50);
        step("pause_violation", 1'b0, 0, 0, 1'b0, 1'b0, mk(0, 0, 0, 1, 1, 2));
        step("pviol_one_cycle", 1'b0, 0, 0, 1'b0, 1'b0, mk(0, 0, 0, 0, 0, 2));
        bus.pausable_i = 1'b1;
        pulses(7, 10, 10);
        step("relock_after_pviol", 1'b1, 10, 10, 1'b1, 1'b0, mk(1, 0, 1, 0, 0, 2));

        // Edge coincident with threshold match: no pause
        step("edge_ew",     1'b0, 0, 0, 1'b1, 1'b0, mk(1, 0, 0, 0, 0, 2));
        idle_cycles(50);
        step("edge_wins",   1'b0, 0, 0, 1'b1, 1'b0, mk(1, 0, 0, 0, 0, 2));
        step("no_pause_after", 1'b0, 0, 0, 1'b0, 1'b0, mk(1, 0, 0, 0, 0, 2));

        // rate_valid + violation together count once
        pulses(0, 0, 0);
        drive(1'b1, 10, 14, 1'b1, 1'b1);
        drive(1'b1, 10, 14, 1'b1, 1'b1);
        step("rv_viol_single", 1'b1, 10, 14, 1'b1, 1'b1, mk(1, 0, 0, 0, 0, 2));
        step("rv_viol_loss",   1'b0, 0, 0, 1'b1, 1'b1, mk(0, 0, 0, 1, 0, 2));

        // 50/50 mode: low rate compared against high limits
        bus.even_50_50_i = 1'b1;
        bus.low_lockin_i = 32'd30;
        pulses(7, 10, 10);
        step("even_lock",  1'b1, 10, 10, 1'b1, 1'b0, mk(1, 0, 1, 0, 0, 2));
        bus.enable_i = 1'b0;
        step("disable_no_lost", 1'b0, 0, 0, 1'b0, 1'b0, mk(0, 0, 0, 0, 0, 0));
        bus.enable_i = 1'b1;
        idle_cycles(1);
        pulses(7, 10, 10);
        step("even_relock", 1'b1, 10, 10, 1'b1, 1'b0, mk(1, 0, 1, 0, 0, 0));

        // Asynchronous reset between clock edges
        #2;
        rst = 1'b1;
        #1;
        push_exp("async_rst", mk(0, 0, 0, 0, 0, 0));
        pop_check();
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle_cycles(1);
        pulses(3, 10, 10);
        rst = 1'b1;
        idle_cycles(1);
        rst = 1'b0;
        idle_cycles(1);
        pulses(6, 10, 10);
        step("rst_clears_match", 1'b1, 10, 10, 1'b1, 1'b0, mk(0, 0, 0, 0, 0, 0));
        step("lock_after_rst",   1'b1, 10, 10, 1'b1, 1'b0, mk(1, 0, 1, 0, 0, 0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
